// File: rtl/program_loader_if.sv
// Word stream from the host into the program loader: valid/ready handshake
// carrying a 9-bit machine-code word and an end-of-program marker.
interface program_loader_if;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Streams machine-code words into a 2**D x 9 program store and serves the
// fetch stage's combinational read port once a complete program is present.
module program_loader #(
  parameter int D = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  program_loader_if.slave      s_if,
  input  logic [D-1:0]         programCounter,
  output logic [8:0]           machineCode,
  output logic                 loaded,
  output logic                 overflow,
  output logic [D:0]           wordCount
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  logic [1:0] r_state;
  logic       r_in_ready;
  logic       r_loaded;
  logic       r_overflow;
  logic [D:0] r_word_count;
  logic [8:0] r_mem [0:(2**D)-1];

  logic         w_accept;
  logic [D-1:0] w_wr_addr;
  logic         w_addr_last;
  logic         w_pc_valid;

  assign w_accept    = s_if.in_valid && r_in_ready;
  assign w_wr_addr   = r_word_count[D-1:0];
  assign w_addr_last = (w_wr_addr == {D{1'b1}});
  assign w_pc_valid  = ({1'b0, programCounter} < r_word_count);

  // Session control: handshake, word counting and completion/overflow status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_loaded     <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_in_ready   <= 1'b1;
            r_word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_word_count <= r_word_count + {{D{1'b0}}, 1'b1};
            // in_last wins over the top address: exact fill is a success.
            if (s_if.in_last) begin
              r_state    <= ST_READY;
              r_in_ready <= 1'b0;
              r_loaded   <= 1'b1;
            end else if (w_addr_last) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_overflow <= 1'b1;
            end
          end
        end
        ST_READY, ST_ERR: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_in_ready   <= 1'b1;
            r_loaded     <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_loaded   <= 1'b0;
          r_overflow <= 1'b0;
        end
      endcase
    end
  end

  // Program store write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[w_wr_addr] <= s_if.in_data;
    end
  end

  // Words beyond the current program, or any word while loading, read as zero.
  assign machineCode   = (r_loaded && w_pc_valid) ? r_mem[programCounter] : 9'd0;
  assign s_if.in_ready = r_in_ready;
  assign loaded        = r_loaded;
  assign overflow      = r_overflow;
  assign wordCount     = r_word_count;

endmodule
